ehl_byte_packer: RTL and testbench

Byte-stream to word packer placed directly upstream of the byte-order converter. Accepts one byte per cycle on a valid/ready handshake, assembles BYTE_CNT bytes into one big-endian word (first byte in the most significant lane), and presents the word on a registered valid/ready output. The downstream converter then swaps it to little-endian when required. Partial final words are supported via a last flag and lane-enable mask.

---
 rtl/ehl_byte_packer_pkg.sv | 25 ++
 rtl/ehl_byte_packer.sv | 160 ++++++++++++++++
 tb/tb_ehl_byte_packer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ehl_byte_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ehl_byte_packer_pkg
// Description : Shared helpers for the ehl byte packer (width computation).
// Revision    : 1.0 - initial release
// ============================================================================
package ehl_byte_packer_pkg;

  // Number of bits needed to count 0..value-1, never less than one bit.
  function automatic int unsigned ehl_clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        width = i + 1;
      end
    end
    if (width == 0) begin
      width = 1;
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ehl_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : ehl_byte_packer
// Description : Packs a byte stream (valid/ready) into big-endian words of
//               BYTE_CNT bytes, first byte in the most significant lane.
//               Output word sits in a registered valid/ready holding stage.
//               Optional feature macro: EHL_BYTE_PACKER_LAST_EN enables
//               packet-end handling (partial words, out_be_o, out_last_o).
// Revision    : 1.0 - initial release
// ============================================================================
module ehl_byte_packer #(
  parameter int unsigned BYTE_CNT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic [7:0]            in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [BYTE_CNT*8-1:0] out_data_o,
  output logic [BYTE_CNT-1:0]   out_be_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  import ehl_byte_packer_pkg::*;

  localparam int unsigned c_cnt_w  = ehl_clog2(BYTE_CNT);
  localparam int unsigned c_word_w = BYTE_CNT * 8;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BYTE_CNT - 1);

  if ((BYTE_CNT < 1) || (BYTE_CNT > 16)) begin : g_bad_byte_cnt
    $error("ehl_byte_packer: BYTE_CNT must be in 1..16");
  end

  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_word_w-1:0] asm_q, asm_d;
  logic [c_word_w-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                w_accept;
  logic                w_last;
  logic                w_done;
  int                  w_lane;
  logic [c_word_w-1:0] w_merged;

  assign in_ready_o  = !clear_i && (!out_valid_q || out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_lane      = int'(BYTE_CNT) - 1 - int'(cnt_q);
  assign w_done      = w_accept && ((cnt_q == c_cnt_max) || w_last);
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  // Assembly word with the incoming byte dropped into its lane; lanes not yet
  // filled are zero because asm_q is cleared whenever a word is emitted.
  always_comb begin
    w_merged = asm_q;
    for (int i = 0; i < int'(BYTE_CNT); i++) begin
      if (i == w_lane) begin
        w_merged[i*8 +: 8] = in_data_i;
      end
    end
  end

`ifdef EHL_BYTE_PACKER_LAST_EN
  logic [BYTE_CNT-1:0] out_be_q, out_be_d;
  logic                out_last_q, out_last_d;
  logic [BYTE_CNT-1:0] w_mask;

  assign w_last     = in_last_i;
  assign out_be_o   = out_be_q;
  assign out_last_o = out_last_q;

  // Lane enables: lanes from the top down to the byte being written.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(BYTE_CNT); i++) begin
      if (i >= w_lane) begin
        w_mask[i] = 1'b1;
      end
    end
  end

  // Packet-end side-band next state, loaded together with the word.
  always_comb begin
    out_be_d   = out_be_q;
    out_last_d = out_last_q;
    if (!clear_i && w_done) begin
      out_be_d   = w_mask;
      out_last_d = in_last_i;
    end
  end

  // Side-band holding registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_be_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      out_be_q   <= out_be_d;
      out_last_q <= out_last_d;
    end
  end
`else
  logic w_unused_last;

  assign w_last        = 1'b0;
  assign w_unused_last = in_last_i;
  assign out_be_o      = '1;
  assign out_last_o    = 1'b0;
`endif

  // Next state for lane counter, assembly word and output holding stage;
  // clear dominates, and a load in the same cycle as a drain keeps valid set.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      cnt_d       = '0;
      asm_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (w_accept) begin
        if (w_done) begin
          cnt_d      = '0;
          asm_d      = '0;
          out_data_d = w_merged;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
          asm_d = w_merged;
        end
      end
      if (w_done) begin
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ehl_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ehl_byte_packer
// Description : Self-checking bench for ehl_byte_packer (BYTE_CNT=4 and 1),
//               directed scenarios plus randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ehl_byte_packer;

  localparam int BC = 4;
`ifdef EHL_BYTE_PACKER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_last, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_be;

  logic        d1_clear, d1_valid, d1_last, d1_oready;
  logic [7:0]  d1_data;
  logic        d1_in_ready, d1_out_last, d1_out_valid;
  logic [7:0]  d1_out_data;
  logic [0:0]  d1_out_be;

  always #5 clk = ~clk;

  ehl_byte_packer #(.BYTE_CNT(BC)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(in_ready), .out_data_o(out_data), .out_be_o(out_be),
    .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  ehl_byte_packer #(.BYTE_CNT(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(d1_clear),
    .in_data_i(d1_data), .in_valid_i(d1_valid), .in_last_i(d1_last),
    .in_ready_o(d1_in_ready), .out_data_o(d1_out_data), .out_be_o(d1_out_be),
    .out_last_o(d1_out_last), .out_valid_o(d1_out_valid), .out_ready_i(d1_oready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes collected so far plus the presented word.
  logic [7:0]  m_q[$];
  bit          m_ov;
  logic [31:0] m_od;
  logic [3:0]  m_be;
  bit          m_last;
  bit          m_rdy;
  bit          dut_rdy;
  logic [31:0] got[$];

  function automatic logic [31:0] pack_word();
    logic [31:0] w;
    w = '0;
    foreach (m_q[i]) w[(BC-1-i)*8 +: 8] = m_q[i];
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ov   = 1'b0;
    m_od   = '0;
    m_be   = LAST_EN ? 4'h0 : 4'hF;
    m_last = 1'b0;
  endtask

  // One clock cycle of stimulus; advances the model and records drained words.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                       input bit ordy, input bit clr);
    bit acc;
    bit fin;
    int n;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; clear = clr;
    #1;
    dut_rdy = in_ready;
    m_rdy   = !clr && (!m_ov || ordy);
    if (out_valid && ordy && !clr) got.push_back(out_data);
    fin = 1'b0;
    if (clr) begin
      m_q.delete();
      m_ov = 1'b0;
    end else begin
      acc = v && m_rdy;
      if (acc) begin
        m_q.push_back(d);
        if (m_q.size() == BC || (LAST_EN && l)) begin
          n    = m_q.size();
          m_od = pack_word();
          if (LAST_EN) begin
            m_be   = 4'(((1 << n) - 1) << (BC - n));
            m_last = l;
          end
          m_q.delete();
          fin = 1'b1;
        end
      end
      if (fin) m_ov = 1'b1;
      else if (m_ov && ordy) m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++;
    if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %08h exp 00000000", out_data); end
    checks++;
    if (out_be !== m_be) begin errors++; $display("FAIL reset_be got %0h exp %0h", out_be, m_be); end
    checks++;
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b exp 0", out_last); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++;
    if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_bc1 got valid %0b ready %0b exp 0 1", d1_out_valid, d1_in_ready);
    end
  endtask

  task automatic test_basic_word();
    cycle(1, 8'h11, 0, 1, 0);
    cycle(1, 8'h22, 0, 1, 0);
    cycle(1, 8'h33, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", out_valid); end
    cycle(1, 8'h44, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11223344) begin
      errors++; $display("FAIL basic_word got v%0b %08h exp v1 11223344", out_valid, out_data);
    end
    checks++;
    if (out_be !== 4'hF || out_last !== 1'b0) begin
      errors++; $display("FAIL basic_be_last got %0h %0b exp f 0", out_be, out_last);
    end
    cycle(0, 8'h00, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h11223344) begin
      errors++; $display("FAIL basic_drain got v%0b %08h exp v0 11223344", out_valid, out_data);
    end
  endtask

  task automatic test_last();
    cycle(1, 8'hAA, 0, 1, 0);
    cycle(1, 8'hBB, 1, 1, 0);
`ifdef EHL_BYTE_PACKER_LAST_EN
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAABB0000 || out_be !== 4'hC || out_last !== 1'b1) begin
      errors++; $display("FAIL last_partial got v%0b %08h be %0h l%0b exp v1 aabb0000 be c l1",
                         out_valid, out_data, out_be, out_last);
    end
`else
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL last_ignored got v%0b exp v0", out_valid); end
    cycle(1, 8'hCC, 0, 1, 0);
    cycle(1, 8'hDD, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAABBCCDD || out_be !== 4'hF || out_last !== 1'b0) begin
      errors++; $display("FAIL last_full got v%0b %08h be %0h l%0b exp v1 aabbccdd be f l0",
                         out_valid, out_data, out_be, out_last);
    end
`endif
    cycle(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_stall();
    int idx = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit ordy;
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h00010203; exp_w[1] = 32'h04050607; exp_w[2] = 32'h08090A0B;
    got.delete();
    for (int c = 0; c < 40; c++) begin
      if (idx >= 12 && !m_ov) break;
      ordy = (stall_left == 0);
      cycle(idx < 12, 8'(idx), 0, ordy, 0);
      checks++;
      if (dut_rdy !== m_rdy || (!ordy && dut_rdy !== 1'b0)) begin
        errors++; $display("FAIL stall_in_ready cyc %0d got %0b exp %0b", c, dut_rdy, m_rdy);
      end
      if (idx < 12 && m_rdy) idx++;
      checks++;
      if (out_valid !== m_ov || out_data !== m_od) begin
        errors++; $display("FAIL stall_out cyc %0d got v%0b %08h exp v%0b %08h", c, out_valid, out_data, m_ov, m_od);
      end
      if (stall_left > 0) stall_left--;
      else if (!stalled && m_ov) begin stall_left = 3; stalled = 1'b1; end
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL stall_count got %0d exp 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin errors++; $display("FAIL stall_word%0d got %08h exp %08h", i, got[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_clear();
    got.delete();
    cycle(1, 8'hE1, 0, 1, 0);
    cycle(1, 8'hE2, 0, 1, 0);
    cycle(1, 8'hFF, 0, 1, 1);
    checks++;
    if (dut_rdy !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %0b exp 0", dut_rdy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %0b exp 0", out_valid); end
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h01020304) begin
      errors++; $display("FAIL clear_word got v%0b %08h exp v1 01020304", out_valid, out_data);
    end
    cycle(0, 8'h00, 0, 1, 0);
    checks++;
    if (got.size() != 1 || got[0] !== 32'h01020304) begin
      errors++; $display("FAIL clear_only_word got %0d words exp 1 word 01020304", got.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1, 8'h10 + 8'(i), 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'h20 + 8'(i), 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h10111213) begin
      errors++; $display("FAIL rstmid_pre got v%0b %08h exp v0 10111213", out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_be !== m_be || out_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got v%0b %08h be %0h l%0b exp v0 00000000 be %0h l0",
                         out_valid, out_data, out_be, out_last, m_be);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 8'h00, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release got v%0b exp v0", out_valid); end
    for (int i = 0; i < 4; i++) cycle(1, 8'h30 + 8'(i), 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h30313233) begin
      errors++; $display("FAIL rstmid_word got v%0b %08h exp v1 30313233", out_valid, out_data);
    end
    cycle(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_random();
    bit v, l, ordy, clr;
    logic [7:0] d;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      d    = 8'($urandom);
      l    = ($urandom_range(0, 5) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 40) == 0);
      cycle(v, d, l, ordy, clr);
      checks++;
      if (dut_rdy !== m_rdy) begin errors++; $display("FAIL rand_in_ready cyc %0d got %0b exp %0b", c, dut_rdy, m_rdy); end
      checks++;
      if (out_valid !== m_ov || out_data !== m_od || out_be !== m_be || out_last !== m_last) begin
        errors++; $display("FAIL rand_out cyc %0d got v%0b %08h be %0h l%0b exp v%0b %08h be %0h l%0b",
                           c, out_valid, out_data, out_be, out_last, m_ov, m_od, m_be, m_last);
      end
    end
    cycle(0, 8'h00, 0, 1, 0);
  endtask

  task automatic test_byte_cnt1();
    @(negedge clk);
    d1_valid = 1'b1; d1_data = 8'h5A;
    #1;
    checks++;
    if (d1_in_ready !== 1'b1) begin errors++; $display("FAIL bc1_ready got %0b exp 1", d1_in_ready); end
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 8'h5A || d1_out_be !== 1'b1) begin
      errors++; $display("FAIL bc1_word0 got v%0b %02h be %0b exp v1 5a be 1", d1_out_valid, d1_out_data, d1_out_be);
    end
    @(negedge clk);
    d1_data = 8'hA5;
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 8'hA5 || d1_out_be !== 1'b1) begin
      errors++; $display("FAIL bc1_word1 got v%0b %02h be %0b exp v1 a5 be 1", d1_out_valid, d1_out_data, d1_out_be);
    end
    @(negedge clk);
    d1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (d1_out_valid !== 1'b0) begin errors++; $display("FAIL bc1_idle got v%0b exp v0", d1_out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b1;
    d1_clear = 1'b0; d1_valid = 1'b0; d1_last = 1'b0; d1_data = 8'h00; d1_oready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    test_reset();
    test_basic_word();
    test_last();
    test_stall();
    test_clear();
    test_reset_mid();
    test_random();
    test_byte_cnt1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
